// File: rtl/ldpc_mem_pkg.sv
// -----------------------------------------------------------------------------
// ldpc_mem_pkg
// Shared definitions for the LDPC memory arbiter slice.
//   - Default RAM geometry (word width, address width).
//   - Arbiter state encoding: SERVE (normal arbitration) and CLEAR (zero sweep).
//   - Requester index constants used for last_grant bookkeeping.
// No ports; imported by the interface, the arbiter top and rr_arb2.
// -----------------------------------------------------------------------------
package ldpc_mem_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    // Named view of the state register, handy in waveforms and checkers.
    typedef enum logic [0:0] {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    // Plain constants for the state register itself (kept as logic vectors
    // so the encoding stays readable by older tools).
    localparam logic [0:0] ST_SERVE = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // last_grant holds the index of the requester that completed last.
    localparam logic REQ_IDX_0 = 1'b0;
    localparam logic REQ_IDX_1 = 1'b1;

endpackage : ldpc_mem_pkg

// File: rtl/ldpc_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// ldpc_mem_arbiter_if
// Bundle of every bus the arbiter talks on:
//   req0_* / req1_*  : two requester ports (valid, we, addr, wdata, ready)
//   rsp0_* / rsp1_*  : read-return ports (valid, data)
//   mem_*            : single-port synchronous RAM port
// Modports:
//   slave  - the arbiter side (consumes requests, drives RAM and responses)
//   master - the requester/RAM environment side
//
// Handshake: a transfer on requester N completes on the rising edge where
// reqN_valid and reqN_ready are both high. reqN_valid must not depend on
// reqN_ready; reqN_ready may depend combinationally on both valids. Responses
// are a one-cycle rspN_valid strobe with no back-pressure; rspN_data is zero
// whenever rspN_valid is low.
// -----------------------------------------------------------------------------
interface ldpc_mem_arbiter_if
    import ldpc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;

    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_data;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_we;
    logic                  mem_cs;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output mem_address, mem_data_in, mem_we, mem_cs,
        input  mem_data_out
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  mem_address, mem_data_in, mem_we, mem_cs,
        output mem_data_out
    );

endinterface : ldpc_mem_arbiter_if

// File: rtl/ldpc_mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin tie breaker, purely combinational.
// Ports:
//   valid0_i, valid1_i : request lines
//   last_grant_i       : index of the requester that completed last
//   grant_o[1:0]       : one-hot grant (bit N = requester N), zero when idle
// A lone valid is always granted; on a tie the requester that did NOT win
// last time is granted.
// -----------------------------------------------------------------------------
module rr_arb2
    import ldpc_mem_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (valid0_i && valid1_i) begin
            grant_o = (last_grant_i == REQ_IDX_1) ? 2'b01 : 2'b10;
        end else if (valid0_i) begin
            grant_o = 2'b01;
        end else if (valid1_i) begin
            grant_o = 2'b10;
        end
    end

endmodule : rr_arb2

// File: rtl/ldpc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// ldpc_mem_arbiter
// Arbitrates two requesters onto one single-port synchronous RAM and owns a
// full-memory zero sweep (CLEAR) that runs after every reset and on request.
// Ports:
//   clk          : sole clock, rising edge
//   reset        : synchronous, active-high; enters CLEAR at address 0
//   clear_start  : pulse in SERVE requesting a zero sweep (beats requests)
//   clear_busy   : high exactly while in CLEAR
//   dbg_state_o  : raw state register (ST_SERVE / ST_CLEAR) for observation
//   bus          : ldpc_mem_arbiter_if.slave (requests, responses, RAM port)
// Behaviour:
//   SERVE - readies are a combinational function of the two valids and
//           last_grant; the granted request goes straight to the RAM pins in
//           the same cycle. Reads return one cycle later on the owner's rsp.
//   CLEAR - readies low, RAM written with zero at a counter that walks
//           0..RAM_DEPTH-1, one word per cycle, then back to SERVE.
// -----------------------------------------------------------------------------
module ldpc_mem_arbiter
    import ldpc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_start,
    output logic                clear_busy,
    output logic [0:0]          dbg_state_o,
    ldpc_mem_arbiter_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q,    clr_cnt_d;
    logic                  last_grant_q, last_grant_d;
    // One pending-read flag per requester: set by a read transfer, shown as
    // rspN_valid the next cycle. At most one can be set at a time.
    logic                  rsp0_pend_q,  rsp0_pend_d;
    logic                  rsp1_pend_q,  rsp1_pend_d;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [1:0] grant;
    logic       serving;
    logic       xfer0;
    logic       xfer1;

    rr_arb2 u_rr_arb2 (
        .valid0_i     (bus.req0_valid),
        .valid1_i     (bus.req1_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // clear_start suppresses any grant in the cycle it arrives so the sweep
    // begins on a clean boundary with no request half-served.
    assign serving = (state_q == ST_SERVE) && !clear_start;

    assign bus.req0_ready = serving && grant[0];
    assign bus.req1_ready = serving && grant[1];

    assign xfer0 = bus.req0_valid && bus.req0_ready;
    assign xfer1 = bus.req1_valid && bus.req1_ready;

    // -------------------------------------------------------------------------
    // RAM port mux: sweep, granted requester, or fully idle (all zero)
    // -------------------------------------------------------------------------
    always_comb begin
        bus.mem_cs      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_address = '0;
        bus.mem_data_in = '0;
        if (state_q == ST_CLEAR) begin
            bus.mem_cs      = 1'b1;
            bus.mem_we      = 1'b1;
            bus.mem_address = clr_cnt_q;
            bus.mem_data_in = '0;
        end else if (xfer0) begin
            bus.mem_cs      = 1'b1;
            bus.mem_we      = bus.req0_we;
            bus.mem_address = bus.req0_addr;
            bus.mem_data_in = bus.req0_wdata;
        end else if (xfer1) begin
            bus.mem_cs      = 1'b1;
            bus.mem_we      = bus.req1_we;
            bus.mem_address = bus.req1_addr;
            bus.mem_data_in = bus.req1_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = last_grant_q;
        // Reads only; writes produce no response.
        rsp0_pend_d  = xfer0 && !bus.req0_we;
        rsp1_pend_d  = xfer1 && !bus.req1_we;

        case (state_q)
            ST_SERVE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                // clear_start is ignored here; the sweep never restarts.
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_SERVE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase

        if (xfer0) begin
            last_grant_d = REQ_IDX_0;
        end else if (xfer1) begin
            last_grant_d = REQ_IDX_1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // last_grant=1 so requester 0 wins the first tie.
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            last_grant_q <= REQ_IDX_1;
            rsp0_pend_q  <= 1'b0;
            rsp1_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            rsp0_pend_q  <= rsp0_pend_d;
            rsp1_pend_q  <= rsp1_pend_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // RAM read data is valid exactly in the cycle after the read, which is
    // the cycle the pending flag is high; it is steered to the owner only.
    assign bus.rsp0_valid = rsp0_pend_q;
    assign bus.rsp1_valid = rsp1_pend_q;
    assign bus.rsp0_data  = rsp0_pend_q ? bus.mem_data_out : '0;
    assign bus.rsp1_data  = rsp1_pend_q ? bus.mem_data_out : '0;

    assign clear_busy  = (state_q == ST_CLEAR);
    assign dbg_state_o = state_q;

endmodule : ldpc_mem_arbiter

// File: tb/tb_ldpc_mem_arbiter.sv
module tb_ldpc_mem_arbiter;
  import ldpc_mem_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic clear_start;
  logic clear_busy;
  logic [0:0] dbg_state;

  always #5 clk = ~clk;

  ldpc_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ldpc_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .dbg_state_o (dbg_state),
    .bus         (bus)
  );

  // ---------------- RAM environment (synchronous single port) ----------------
  logic [DW-1:0] ram [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) ram[bus.mem_address] <= bus.mem_data_in;
      else            bus.mem_data_out     <= ram[bus.mem_address];
    end
  end

  // ---------------- counters / check helper ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  // Model state: whether a sweep is running and where, who completed last,
  // the single expected response (owner + data), and a shadow of RAM contents.
  bit            m_started = 0;
  bit            m_clear;
  int            m_clr;
  int            m_last;
  bit            m_pv;
  int            m_po;
  logic [DW-1:0] m_pd;
  logic [DW-1:0] shadow [DEPTH];

  always @(negedge clk) begin
    int            win;
    logic          e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_rv0, e_rv1;
    logic [DW-1:0] e_rd0, e_rd1;
    if (reset) begin
      m_started = 1;
      m_clear = 1; m_clr = 0; m_last = 1; m_pv = 0;
    end else if (m_started) begin
      win = -1;
      if (!m_clear && !clear_start) begin
        if (bus.req0_valid && bus.req1_valid) win = (m_last == 0) ? 1 : 0;
        else if (bus.req0_valid) win = 0;
        else if (bus.req1_valid) win = 1;
      end
      e_cs = 0; e_we = 0; e_addr = '0; e_wd = '0;
      if (m_clear) begin
        e_cs = 1; e_we = 1; e_addr = AW'(m_clr);
      end else if (win == 0) begin
        e_cs = 1; e_we = bus.req0_we; e_addr = bus.req0_addr; e_wd = bus.req0_wdata;
      end else if (win == 1) begin
        e_cs = 1; e_we = bus.req1_we; e_addr = bus.req1_addr; e_wd = bus.req1_wdata;
      end
      e_rv0 = m_pv && (m_po == 0);
      e_rv1 = m_pv && (m_po == 1);
      e_rd0 = e_rv0 ? m_pd : '0;
      e_rd1 = e_rv1 ? m_pd : '0;

      chk("clear_busy", clear_busy, m_clear);
      chk("dbg_state", dbg_state, m_clear);
      chk("req0_ready", bus.req0_ready, win == 0);
      chk("req1_ready", bus.req1_ready, win == 1);
      chk("ready_excl", bus.req0_ready & bus.req1_ready, 0);
      chk("mem_cs", bus.mem_cs, e_cs);
      chk("mem_we", bus.mem_we, e_we);
      chk("mem_address", bus.mem_address, e_addr);
      chk("mem_data_in", bus.mem_data_in, e_wd);
      chk("rsp0_valid", bus.rsp0_valid, e_rv0);
      chk("rsp0_data", bus.rsp0_data, e_rd0);
      chk("rsp1_valid", bus.rsp1_valid, e_rv1);
      chk("rsp1_data", bus.rsp1_data, e_rd1);

      // advance model to the next cycle
      m_pv = 0;
      if (m_clear) begin
        shadow[m_clr] = '0;
        if (m_clr == DEPTH - 1) m_clear = 0;
        else m_clr++;
      end else if (clear_start) begin
        m_clear = 1; m_clr = 0;
      end else if (win >= 0) begin
        m_last = win;
        if (e_we) shadow[e_addr] = e_wd;
        else begin
          m_pv = 1; m_po = win; m_pd = shadow[e_addr];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_start     = 0;
    bus.req0_valid  = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid  = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
  endtask

  // Counts cycles with clear_busy high, starting with the current cycle.
  // Returns at the negedge of the first non-busy cycle.
  task automatic wait_clear(output int cnt);
    int guard;
    cnt = 0;
    guard = 0;
    while (guard < 2000) begin
      @(negedge clk);
      if (!clear_busy) break;
      cnt++;
      guard++;
    end
    if (guard >= 2000) chk("clear_timeout", 1, 0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int cnt;
    int guard;
    int r;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    idle();
    reset = 1;
    repeat (3) tick();
    reset = 0;

    // After reset: full sweep of exactly DEPTH cycles starting at address 0.
    @(negedge clk);
    chk("reset_first_busy", clear_busy, 1);
    chk("reset_first_addr", bus.mem_address, 0);
    wait_clear(cnt);
    chk("reset_clear_len", cnt + 1, 256);
    tick();

    // Write 0x5A@0x10 from req0, then read it back on req1.
    bus.req0_valid = 1; bus.req0_we = 1; bus.req0_addr = 8'h10; bus.req0_wdata = 8'h5A;
    tick();
    idle();
    bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 8'h10;
    tick();
    idle();
    @(negedge clk);
    chk("wr_rd_rsp1_valid", bus.rsp1_valid, 1);
    chk("wr_rd_rsp1_data", bus.rsp1_data, 8'h5A);
    chk("wr_rd_rsp0_valid", bus.rsp0_valid, 0);
    tick();

    // Both valid: grants alternate 0,1,0,1 (last completion was req1).
    bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 8'h01;
    bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_ready0", bus.req0_ready, (i % 2 == 0));
      chk("alt_ready1", bus.req1_ready, (i % 2 == 1));
      tick();
    end
    idle();
    tick();

    // clear_start together with req0_valid: no grant, req0 waits 256 cycles.
    clear_start = 1;
    bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 8'h03;
    @(negedge clk);
    chk("cs_prio_ready0", bus.req0_ready, 0);
    tick();
    clear_start = 0;
    cnt = 0;
    guard = 0;
    while (guard < 1000) begin
      @(negedge clk);
      if (cnt == 0) begin
        chk("cs_first_busy", clear_busy, 1);
        chk("cs_first_addr", bus.mem_address, 0);
      end
      if (bus.req0_ready) break;
      cnt++;
      guard++;
      tick();
    end
    if (guard >= 1000) chk("cs_wait_timeout", 1, 0);
    chk("cs_req0_wait", cnt, 256);
    tick();
    idle();

    // Read by req1, then clear_start the next cycle with req1 still valid.
    bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 8'h10;
    tick();
    clear_start = 1;
    @(negedge clk);
    chk("rd_cs_ready1", bus.req1_ready, 0);
    chk("rd_cs_rsp1_valid", bus.rsp1_valid, 1);
    chk("rd_cs_rsp1_data", bus.rsp1_data, 8'h00);
    tick();
    idle();
    wait_clear(cnt);
    chk("rd_cs_clear_len", cnt, 256);
    tick();

    // Reset mid-sweep near address 100: sweep restarts for a full DEPTH.
    clear_start = 1;
    tick();
    clear_start = 0;
    guard = 0;
    while (guard < 1000) begin
      @(negedge clk);
      if (clear_busy && bus.mem_address == 8'd100) break;
      guard++;
    end
    if (guard >= 1000) chk("addr100_timeout", 1, 0);
    tick();
    reset = 1;
    tick();
    reset = 0;
    wait_clear(cnt);
    chk("midsweep_reset_len", cnt, 256);
    tick();

    // Reset in the cycle of a read: its response must be dropped.
    bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 8'h10;
    reset = 1;
    tick();
    reset = 0;
    idle();
    @(negedge clk);
    chk("rst_read_rsp1_dropped", bus.rsp1_valid, 0);
    wait_clear(cnt);
    chk("rst_read_clear_len", cnt + 1, 256);
    tick();

    // Randomised traffic over a small address window so reads hit writes.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      reset = (r < 2);
      clear_start = (r >= 2 && r < 6);
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req0_we    = $urandom_range(0, 1);
      bus.req0_addr  = AW'($urandom_range(0, 15));
      bus.req0_wdata = DW'($urandom);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req1_we    = $urandom_range(0, 1);
      bus.req1_addr  = AW'($urandom_range(0, 15));
      bus.req1_wdata = DW'($urandom);
      tick();
    end
    reset = 0;
    idle();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ldpc_mem_arbiter
